fetch_stage: RTL and testbench
==============================

// Module: fetch_stage
// PURPOSE
//  Instruction-fetch stage of the 16-bit pipelined CPU, directly upstream of data_path.
//  Owns the PC and issues one instruction-memory request at a time.
//  Delivers IR plus its PC to decode/data_path over a valid/ready handshake.
//  Takes branch/jump redirects from data_path and flushes wrong-path fetches.
// PARAMETERS
//  DATA_W   16      instruction width (IR width)
//  ADDR_W   16      PC / instruction address width
//  RESET_PC 'h0000  PC value loaded on reset
//  PC_INC   1       PC increment per fetch (word-addressed memory)
// PORTS
//  clk            in   1       clock; all state updates on rising edge
//  reset          in   1       asynchronous, active-high reset
//  imem_req_valid out  1       fetch request valid
//  imem_req_ready in   1       memory accepts request this cycle
//  imem_addr      out  ADDR_W  fetch address (= pc)
//  imem_rsp_valid in   1       response data valid (no backpressure, >=1 cycle after accept)
//  imem_rsp_data  in   DATA_W  fetched instruction
//  IR             out  DATA_W  instruction to data_path
//  if_pc          out  ADDR_W  address of IR
//  if_valid       out  1       IR/if_pc valid
//  id_ready       in   1       downstream consumes IR when if_valid && id_ready
//  redirect_valid in   1       branch taken / flush request
//  redirect_pc    in   ADDR_W  new fetch address
// BEHAVIOUR
//  Reset (async, immediate): pc=RESET_PC, state=REQ, IR=0, if_pc=0, if_valid=0,
//    skid buffer empty, imem_req_valid=0 while reset is high.
//  FSM states: REQ, WAIT, HOLD, DROP. Exactly one request outstanding at most.
//  REQ: imem_req_valid = !redirect_valid; imem_addr = pc.
//    On accept: pc_req<=pc, pc<=pc+PC_INC (wraps mod 2^ADDR_W), go WAIT.
//  WAIT: on imem_rsp_valid:
//    - output slot free (!if_valid or id_ready): IR<=data, if_pc<=pc_req, if_valid<=1, go REQ.
//    - else: capture data and pc_req in skid, go HOLD.
//  HOLD: no request issued; when id_ready, move skid to IR/if_pc, if_valid stays 1, go REQ.
//  Output: a transfer occurs when if_valid && id_ready; if_valid clears after transfer
//    unless reloaded in the same cycle. IR/if_pc hold stable while if_valid && !id_ready.
//  Redirect (any state, highest priority):
//    - pc<=redirect_pc; if_valid<=0; skid discarded.
//    - No request is issued in a redirect cycle.
//    - From WAIT without rsp_valid in the same cycle: go DROP.
//    - From WAIT with rsp_valid in the same cycle: discard data, go REQ.
//    - From REQ or HOLD: go REQ.
//    - From DROP: stay DROP, pc updated.
//  DROP: discard next imem_rsp_valid (no IR update), then go REQ.
//  Throughput: at most one instruction per 2 cycles with 1-cycle memory latency.
//  Address wrap: pc 'hFFFF + 1 = 'h0000, no error.
//  Reset mid-transaction: any outstanding response arriving after reset release is
//    ignored (state REQ); the memory is reset in the same domain.
// TESTING
//  1. Reset, 1-cycle memory, id_ready=1 -> addresses 0,1,2,3 issued; IR sequence matches
//     mem[0..3]; if_pc 0,1,2,3.
//  2. id_ready=0 for 5 cycles after first IR -> IR/if_pc stable; second response lands in skid
//     (HOLD); no new request; on id_ready, IR=mem[1], if_pc=1.
//  3. redirect_valid with redirect_pc='h0040 while in WAIT -> stale response dropped,
//     if_valid=0, next request addr='h0040.
//  4. redirect_valid same cycle as imem_rsp_valid -> data discarded, next req addr=redirect_pc.
//  5. redirect_pc='hFFFF, run 3 fetches -> addresses 'hFFFF,'h0000,'h0001.
//  6. Assert reset while in HOLD with if_valid=1 -> all outputs zero immediately; first request
//     after release at RESET_PC.

Source files
------------

// File: rtl/fetch_stage.sv
// fetch_stage: PC owner issuing one outstanding imem request, delivering IR/if_pc over valid/ready
// with a one-entry skid buffer and redirect flush of wrong-path fetches.
module fetch_stage #(
  parameter int                DATA_W   = 16,
  parameter int                ADDR_W   = 16,
  parameter logic [ADDR_W-1:0] RESET_PC = '0,
  parameter int                PC_INC   = 1
) (
  input  logic              clk,
  input  logic              reset,
  output logic              imem_req_valid,
  input  logic              imem_req_ready,
  output logic [ADDR_W-1:0] imem_addr,
  input  logic              imem_rsp_valid,
  input  logic [DATA_W-1:0] imem_rsp_data,
  output logic [DATA_W-1:0] IR,
  output logic [ADDR_W-1:0] if_pc,
  output logic              if_valid,
  input  logic              id_ready,
  input  logic              redirect_valid,
  input  logic [ADDR_W-1:0] redirect_pc
);
  typedef enum logic [1:0] {S_REQ, S_WAIT, S_HOLD, S_DROP} state_t;
  state_t state_q, state_d;
  logic [ADDR_W-1:0] pc_q, pc_d, pc_req_q, pc_req_d, if_pc_q, if_pc_d, skid_pc_q, skid_pc_d;
  logic [DATA_W-1:0] ir_q, ir_d, skid_q, skid_d;
  logic              if_valid_q, if_valid_d;
  logic              req_fire, rsp_in, slot_free;
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q    <= S_REQ;
      pc_q       <= RESET_PC;
      pc_req_q   <= '0;
      ir_q       <= '0;
      if_pc_q    <= '0;
      if_valid_q <= 1'b0;
      skid_q     <= '0;
      skid_pc_q  <= '0;
    end else begin
      state_q    <= state_d;
      pc_q       <= pc_d;
      pc_req_q   <= pc_req_d;
      ir_q       <= ir_d;
      if_pc_q    <= if_pc_d;
      if_valid_q <= if_valid_d;
      skid_q     <= skid_d;
      skid_pc_q  <= skid_pc_d;
    end
  end
  assign req_fire  = imem_req_valid && imem_req_ready;
  assign rsp_in    = state_q == S_WAIT && imem_rsp_valid;
  assign slot_free = !if_valid_q || id_ready;
  // A redirect while a response is still owed parks in DROP so the stale word is swallowed.
  always_comb begin
    state_d = state_q;
    if (redirect_valid)
      state_d = (state_q == S_WAIT || state_q == S_DROP) && !imem_rsp_valid ? S_DROP : S_REQ;
    else
      case (state_q)
        S_REQ:   state_d = req_fire ? S_WAIT : S_REQ;
        S_WAIT:  state_d = !imem_rsp_valid ? S_WAIT : slot_free ? S_REQ : S_HOLD;
        S_HOLD:  state_d = id_ready ? S_REQ : S_HOLD;
        default: state_d = imem_rsp_valid ? S_REQ : S_DROP;
      endcase
  end
  always_comb begin
    pc_d       = pc_q;
    pc_req_d   = pc_req_q;
    ir_d       = ir_q;
    if_pc_d    = if_pc_q;
    skid_d     = skid_q;
    skid_pc_d  = skid_pc_q;
    if_valid_d = if_valid_q && !id_ready;
    if (redirect_valid) begin
      pc_d       = redirect_pc;
      if_valid_d = 1'b0;
    end else begin
      if (req_fire) begin
        pc_req_d = pc_q;
        pc_d     = pc_q + ADDR_W'(PC_INC);
      end
      if (rsp_in && slot_free) begin
        ir_d       = imem_rsp_data;
        if_pc_d    = pc_req_q;
        if_valid_d = 1'b1;
      end
      if (rsp_in && !slot_free) begin
        skid_d    = imem_rsp_data;
        skid_pc_d = pc_req_q;
      end
      if (state_q == S_HOLD && id_ready) begin
        ir_d       = skid_q;
        if_pc_d    = skid_pc_q;
        if_valid_d = 1'b1;
      end
    end
  end
  assign imem_req_valid = !reset && state_q == S_REQ && !redirect_valid;
  assign imem_addr      = pc_q;
  assign IR             = ir_q;
  assign if_pc          = if_pc_q;
  assign if_valid       = if_valid_q;
endmodule

// File: tb/tb_fetch_stage.sv
// tb_fetch_stage: directed scenarios plus random traffic against an in-order instruction-stream
// model: delivered words follow the PC sequence from the last redirect, each equal to mem(pc).
module tb_fetch_stage;
  logic        clk = 1'b0;
  logic        reset = 1'b0;
  logic        imem_req_valid, imem_req_ready;
  logic [15:0] imem_addr;
  logic        imem_rsp_valid;
  logic [15:0] imem_rsp_data;
  logic [15:0] IR, if_pc;
  logic        if_valid, id_ready, redirect_valid;
  logic [15:0] redirect_pc;

  fetch_stage dut (
    .clk(clk), .reset(reset),
    .imem_req_valid(imem_req_valid), .imem_req_ready(imem_req_ready), .imem_addr(imem_addr),
    .imem_rsp_valid(imem_rsp_valid), .imem_rsp_data(imem_rsp_data),
    .IR(IR), .if_pc(if_pc), .if_valid(if_valid), .id_ready(id_ready),
    .redirect_valid(redirect_valid), .redirect_pc(redirect_pc)
  );

  always #5 clk = ~clk;

  int          vec = 0, fails = 0, xfers = 0, cnt = 0, lat_lo = 1, lat_hi = 1;
  logic        pend = 1'b0, hold_chk = 1'b0, last_req = 1'b0;
  logic [15:0] paddr = '0, h_ir = '0, h_pc = '0, exp_pc = '0, exp_req = '0;
  logic [15:0] req_q[$];

  function automatic logic [15:0] memf(input logic [15:0] a);
    return (a * 16'd40503) ^ 16'hC3A5;
  endfunction

  task automatic clr_model();
    pend = 1'b0; hold_chk = 1'b0; last_req = 1'b0; exp_pc = '0; exp_req = '0; xfers = 0;
    req_q.delete();
  endtask

  task automatic do_reset();
    reset = 1'b1; imem_req_ready = 1'b0; imem_rsp_valid = 1'b0; imem_rsp_data = '0;
    id_ready = 1'b0; redirect_valid = 1'b0; redirect_pc = '0;
    clr_model();
    @(negedge clk); @(negedge clk);
    reset = 1'b0;
  endtask

  // One clock: check pre-edge behaviour against the stream model, then advance memory model.
  task automatic tick();
    logic rf, xf;
    logic [15:0] ra;
    int lat;
    #1;
    rf = imem_req_valid && imem_req_ready;
    ra = imem_addr;
    xf = if_valid && id_ready;
    if (hold_chk) begin
      vec++;
      if (if_valid !== 1'b1 || IR !== h_ir || if_pc !== h_pc) begin
        fails++;
        $display("FAIL stable: got v=%b ir=%h pc=%h, need v=1 ir=%h pc=%h", if_valid, IR, if_pc, h_ir, h_pc);
      end
    end
    if (redirect_valid) begin
      vec++;
      if (imem_req_valid !== 1'b0) begin
        fails++;
        $display("FAIL redirect_noreq: got req_valid=%b, need 0", imem_req_valid);
      end
    end
    if (rf) begin
      vec++;
      if (ra !== exp_req || pend || imem_rsp_valid) begin
        fails++;
        $display("FAIL req_addr: got %h (outstanding=%b), need %h with none outstanding", ra, pend | imem_rsp_valid, exp_req);
      end
      exp_req = exp_req + 16'd1;
      req_q.push_back(ra);
    end
    if (xf && !redirect_valid) begin
      vec++;
      if (if_pc !== exp_pc || IR !== memf(exp_pc)) begin
        fails++;
        $display("FAIL deliver: got pc=%h ir=%h, need pc=%h ir=%h", if_pc, IR, exp_pc, memf(exp_pc));
      end
      exp_pc = exp_pc + 16'd1;
      xfers++;
    end
    hold_chk = if_valid && !id_ready && !redirect_valid;
    h_ir = IR;
    h_pc = if_pc;
    if (redirect_valid) begin
      exp_pc = redirect_pc;
      exp_req = redirect_pc;
    end
    @(negedge clk);
    imem_rsp_valid = 1'b0;
    if (rf) begin
      lat = int'($urandom_range(lat_hi, lat_lo));
      pend = 1'b1; cnt = lat - 1; paddr = ra;
    end
    if (pend) begin
      if (cnt == 0) begin
        imem_rsp_valid = 1'b1; imem_rsp_data = memf(paddr); pend = 1'b0;
      end else cnt--;
    end
    last_req = rf;
  endtask

  task automatic test_reset();
    reset = 1'b1; imem_req_ready = 1'b1; id_ready = 1'b1; redirect_valid = 1'b0;
    imem_rsp_valid = 1'b0; imem_rsp_data = '0; redirect_pc = '0;
    clr_model();
    @(negedge clk); @(negedge clk);
    #1;
    vec++;
    if (imem_req_valid !== 1'b0 || IR !== 16'h0 || if_pc !== 16'h0 || if_valid !== 1'b0) begin
      fails++;
      $display("FAIL reset_state: got req=%b ir=%h pc=%h v=%b, need all 0", imem_req_valid, IR, if_pc, if_valid);
    end
    reset = 1'b0;
    #1;
    vec++;
    if (imem_req_valid !== 1'b1 || imem_addr !== 16'h0000) begin
      fails++;
      $display("FAIL reset_first_req: got req=%b addr=%h, need 1 0000", imem_req_valid, imem_addr);
    end
    @(negedge clk);
    clr_model();
  endtask

  task automatic test_sequential();
    int cyc;
    do_reset();
    lat_lo = 1; lat_hi = 1; imem_req_ready = 1'b1; id_ready = 1'b1;
    cyc = 0;
    while (cyc < 40 && xfers < 4) begin tick(); cyc++; end
    vec++;
    if (xfers != 4 || cyc > 9) begin
      fails++;
      $display("FAIL seq_rate: got %0d xfers in %0d cycles, need 4 within 9", xfers, cyc);
    end
    for (int i = 0; i < 4; i++) begin
      vec++;
      if (req_q.size() <= i || req_q[i] !== 16'(i)) begin
        fails++;
        $display("FAIL seq_addr%0d: got %h, need %h", i, req_q.size() > i ? req_q[i] : 16'hxxxx, 16'(i));
      end
    end
  endtask

  task automatic test_backpressure();
    do_reset();
    lat_lo = 1; lat_hi = 1; imem_req_ready = 1'b1; id_ready = 1'b0;
    for (int i = 0; i < 10 && !if_valid; i++) tick();
    for (int i = 0; i < 5; i++) begin
      tick();
      if (i >= 1) begin
        vec++;
        if (imem_req_valid !== 1'b0) begin
          fails++;
          $display("FAIL hold_noreq%0d: got req_valid=%b, need 0", i, imem_req_valid);
        end
      end
    end
    vec++;
    if (if_valid !== 1'b1 || if_pc !== 16'h0 || IR !== memf(16'h0)) begin
      fails++;
      $display("FAIL hold_first: got v=%b pc=%h ir=%h, need 1 0000 %h", if_valid, if_pc, IR, memf(16'h0));
    end
    id_ready = 1'b1;
    tick();
    vec++;
    if (if_valid !== 1'b1 || if_pc !== 16'h1 || IR !== memf(16'h1)) begin
      fails++;
      $display("FAIL skid_release: got v=%b pc=%h ir=%h, need 1 0001 %h", if_valid, if_pc, IR, memf(16'h1));
    end
  endtask

  task automatic test_redirect_wait();
    do_reset();
    lat_lo = 3; lat_hi = 3; imem_req_ready = 1'b1; id_ready = 1'b1;
    for (int i = 0; i < 10 && !last_req; i++) tick();
    redirect_valid = 1'b1; redirect_pc = 16'h0040;
    tick();
    redirect_valid = 1'b0;
    vec++;
    if (if_valid !== 1'b0) begin
      fails++;
      $display("FAIL redir_wait_valid: got %b, need 0", if_valid);
    end
    req_q.delete();
    for (int i = 0; i < 20 && req_q.size() == 0; i++) tick();
    vec++;
    if (req_q.size() == 0 || req_q[0] !== 16'h0040) begin
      fails++;
      $display("FAIL redir_wait_addr: got %h, need 0040", req_q.size() > 0 ? req_q[0] : 16'hxxxx);
    end
    for (int i = 0; i < 20 && xfers < 1; i++) tick();
    vec++;
    if (xfers != 1) begin
      fails++;
      $display("FAIL redir_wait_deliver: got %0d xfers, need 1", xfers);
    end
  endtask

  task automatic test_redirect_rsp();
    do_reset();
    lat_lo = 1; lat_hi = 1; imem_req_ready = 1'b1; id_ready = 1'b1;
    for (int i = 0; i < 10 && !last_req; i++) tick();
    redirect_valid = 1'b1; redirect_pc = 16'h1234;
    tick();
    redirect_valid = 1'b0;
    #1;
    vec++;
    if (if_valid !== 1'b0 || imem_req_valid !== 1'b1 || imem_addr !== 16'h1234) begin
      fails++;
      $display("FAIL redir_rsp: got v=%b req=%b addr=%h, need 0 1 1234", if_valid, imem_req_valid, imem_addr);
    end
    for (int i = 0; i < 20 && xfers < 2; i++) tick();
  endtask

  task automatic test_wrap();
    do_reset();
    lat_lo = 1; lat_hi = 1; imem_req_ready = 1'b1; id_ready = 1'b1;
    redirect_valid = 1'b1; redirect_pc = 16'hFFFF;
    tick();
    redirect_valid = 1'b0;
    req_q.delete();
    for (int i = 0; i < 30 && xfers < 3; i++) tick();
    for (int i = 0; i < 3; i++) begin
      vec++;
      if (req_q.size() <= i || req_q[i] !== 16'hFFFF + 16'(i)) begin
        fails++;
        $display("FAIL wrap_addr%0d: got %h, need %h", i, req_q.size() > i ? req_q[i] : 16'hxxxx, 16'hFFFF + 16'(i));
      end
    end
  endtask

  task automatic test_reset_hold();
    do_reset();
    lat_lo = 1; lat_hi = 1; imem_req_ready = 1'b1; id_ready = 1'b0;
    for (int i = 0; i < 10 && !if_valid; i++) tick();
    for (int i = 0; i < 3; i++) tick();
    #2 reset = 1'b1;
    #1;
    vec++;
    if (IR !== 16'h0 || if_pc !== 16'h0 || if_valid !== 1'b0 || imem_req_valid !== 1'b0) begin
      fails++;
      $display("FAIL async_reset: got ir=%h pc=%h v=%b req=%b, need all 0", IR, if_pc, if_valid, imem_req_valid);
    end
    @(negedge clk);
    reset = 1'b0; imem_rsp_valid = 1'b1; imem_rsp_data = 16'hDEAD;
    imem_req_ready = 1'b0; id_ready = 1'b1;
    clr_model();
    tick();
    vec++;
    if (if_valid !== 1'b0) begin
      fails++;
      $display("FAIL stale_after_reset: got if_valid=%b, need 0", if_valid);
    end
    imem_req_ready = 1'b1;
    for (int i = 0; i < 10 && req_q.size() == 0; i++) tick();
    vec++;
    if (req_q.size() == 0 || req_q[0] !== 16'h0000) begin
      fails++;
      $display("FAIL reset_restart: got %h, need 0000", req_q.size() > 0 ? req_q[0] : 16'hxxxx);
    end
  endtask

  task automatic test_random();
    do_reset();
    lat_lo = 1; lat_hi = 3;
    for (int i = 0; i < 3000; i++) begin
      id_ready       = $urandom_range(9, 0) < 7;
      imem_req_ready = $urandom_range(9, 0) < 7;
      redirect_valid = $urandom_range(19, 0) == 0;
      redirect_pc    = $urandom_range(3, 0) == 0 ? 16'hFFFE : 16'($urandom);
      tick();
    end
    redirect_valid = 1'b0;
    vec++;
    if (xfers < 200) begin
      fails++;
      $display("FAIL random_progress: got %0d xfers, need at least 200", xfers);
    end
  endtask

  initial begin
    test_reset();
    test_sequential();
    test_backpressure();
    test_redirect_wait();
    test_redirect_rsp();
    test_wrap();
    test_reset_hold();
    test_random();
    $display("== %0d vectors applied, %0d miscompares ==", vec, fails);
    $finish;
  end

  initial begin
    #1000000;
    $display("FAIL timeout: simulation did not finish in time");
    $fatal(1);
  end
endmodule
